// File: rtl/instruction_cache_responder.sv
// instruction_cache_responder
//   Responder side of the instruction-fetch interface. Looks each accepted
//   fetch up in a direct-mapped, one-word-per-line cache. On a miss it reads
//   the word from backing memory over a req/ack handshake, installs it, and
//   then responds.
// Ports
//   clock, reset_n                : clock, async active-low reset
//   req_valid/req_addr/req_ready  : fetch request channel (addr[1:0] ignored)
//   resp_valid/resp_instruction/resp_hit : one-cycle response pulse + data
//   flush                         : invalidate every line
//   mem_req/mem_addr              : backing-memory read request (level)
//   mem_ack/mem_rdata             : backing-memory data return
module instruction_cache_responder #(
  parameter int LINES = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [31:0] req_addr,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_instruction,
  output logic        resp_hit,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int IW = $clog2(LINES);
  localparam int TW = 30 - IW;

  typedef enum logic {S_IDLE, S_FILL} state_t;

  state_t           r_state, w_state_nxt;
  logic [LINES-1:0] r_valid, w_valid_nxt;
  logic [TW-1:0]    r_tag  [LINES];
  logic [31:0]      r_data [LINES];
  logic [29:0]      r_fill_waddr;   // word address of the fill in flight

  logic [IW-1:0]    w_idx;
  logic [TW-1:0]    w_tag;
  logic [IW-1:0]    w_fidx;
  logic [TW-1:0]    w_ftag;
  logic             w_hit, w_miss, w_fill_done;
  logic             w_unused;

  assign w_idx    = req_addr[IW+1:2];
  assign w_tag    = req_addr[31:IW+2];
  assign w_fidx   = r_fill_waddr[IW-1:0];
  assign w_ftag   = r_fill_waddr[29:IW];
  assign mem_addr = {r_fill_waddr, 2'b00};
  assign w_unused = ^req_addr[1:0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // req_ready/mem_req decode straight from state so a reset mid-fill drops
  // mem_req immediately.
  always_comb begin
    w_state_nxt = r_state;
    w_hit       = 1'b0;
    w_miss      = 1'b0;
    w_fill_done = 1'b0;
    req_ready   = 1'b0;
    mem_req     = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (r_valid[w_idx] && (r_tag[w_idx] == w_tag)) begin
            w_hit = 1'b1;
          end else begin
            w_miss      = 1'b1;
            w_state_nxt = S_FILL;
          end
        end
      end
      S_FILL: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          w_fill_done = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Flush clears everything, but a fill landing on the same edge wins for
  // its own line.
  always_comb begin
    w_valid_nxt = r_valid;
    if (flush)       w_valid_nxt = '0;
    if (w_fill_done) w_valid_nxt[w_fidx] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_valid <= '0;
    else          r_valid <= w_valid_nxt;
  end

  // Tag/data arrays carry no reset; the valid bits gate them.
  always_ff @(posedge clock) begin
    if (w_fill_done) begin
      r_tag[w_fidx]  <= w_ftag;
      r_data[w_fidx] <= mem_rdata;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid       <= 1'b0;
      resp_hit         <= 1'b0;
      resp_instruction <= '0;
      r_fill_waddr     <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (w_hit) begin
        resp_valid       <= 1'b1;
        resp_hit         <= 1'b1;
        resp_instruction <= r_data[w_idx];
      end else if (w_fill_done) begin
        resp_valid       <= 1'b1;
        resp_hit         <= 1'b0;
        resp_instruction <= mem_rdata;
      end
      if (w_miss) r_fill_waddr <= req_addr[31:2];
    end
  end
endmodule

// File: tb/tb_instruction_cache_responder.sv
// Bench for instruction_cache_responder: directed table, hand-written corner
// sequences and randomized fetches checked against a line-level cache model.
module tb_instruction_cache_responder;
  localparam int LINES = 16;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_instruction;
  logic        resp_hit;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  instruction_cache_responder #(.LINES(LINES)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_instruction(resp_instruction),
    .resp_hit(resp_hit), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: per line, valid + full word address + data.
  bit          m_valid [LINES];
  logic [31:0] m_addr  [LINES];
  logic [31:0] m_data  [LINES];

  typedef struct {
    logic [31:0] addr;
    int          w;
    bit          fa;
    bit          eh;
  } vec_t;
  vec_t tbl [8];

  function automatic logic [31:0] memfun(logic [31:0] a);
    if (a == 32'h0040_0000) return 32'h2008_000A;
    return {a[15:0], a[31:16]} ^ 32'h9E37_79B9;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
  endtask

  task automatic model_install(logic [31:0] wa);
    int ix;
    ix = int'((wa >> 2) % LINES);
    m_valid[ix] = 1'b1;
    m_addr[ix]  = wa;
    m_data[ix]  = memfun(wa);
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    model_clear();
  endtask

  // One fetch; entered and left just after a falling edge.
  task automatic run(input logic [31:0] a, input int w, input bit fa, output bit hit);
    logic [31:0] wa, ed;
    bit          eh;
    int          ix;
    wa  = a & ~32'h3;
    ix  = int'((wa >> 2) % LINES);
    eh  = m_valid[ix] && (m_addr[ix] == wa);
    ed  = eh ? m_data[ix] : memfun(wa);
    hit = 1'b0;
    chk("ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = a;
    @(negedge clock);
    req_valid = 1'b0;
    if (resp_valid) begin
      hit = resp_hit;
      chk("hit_data", resp_instruction, ed);
    end else if (mem_req) begin
      chk("mem_addr", mem_addr, wa);
      chk("ready_fill", req_ready, 0);
      for (int k = 0; k < w; k++) begin
        @(negedge clock);
        chk("mem_req_hold", mem_req, 1);
        chk("mem_addr_hold", mem_addr, wa);
        chk("no_early_resp", resp_valid, 0);
      end
      mem_ack   = 1'b1;
      mem_rdata = memfun(wa);
      flush     = fa;
      @(negedge clock);
      mem_ack   = 1'b0;
      flush     = 1'b0;
      mem_rdata = $urandom;
      chk("fill_resp_valid", resp_valid, 1);
      chk("fill_resp_hit", resp_hit, 0);
      chk("fill_data", resp_instruction, memfun(wa));
      chk("ready_after_fill", req_ready, 1);
      hit = resp_hit;
    end else begin
      chk("no_response", {resp_valid, mem_req}, 2'b01);
    end
    chk("hit_flag", hit, eh);
    if (!eh) begin
      if (fa) model_clear();
      model_install(wa);
    end
  endtask

  initial begin
    bit          h;
    logic [31:0] a;
    tbl[0] = '{32'h0040_0000, 3, 1'b0, 1'b0};  // cold miss
    tbl[1] = '{32'h0040_0000, 0, 1'b0, 1'b1};  // re-request hits
    tbl[2] = '{32'h0040_0004, 1, 1'b0, 1'b0};
    tbl[3] = '{32'h0040_0008, 0, 1'b0, 1'b0};
    tbl[4] = '{32'h0040_0040, 2, 1'b0, 1'b0};  // evicts 0x00400000
    tbl[5] = '{32'h0040_0000, 1, 1'b0, 1'b0};  // refill after eviction
    tbl[6] = '{32'h0040_0000, 0, 1'b0, 1'b1};
    tbl[7] = '{32'h0040_0003, 0, 1'b0, 1'b1};  // low bits ignored

    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    model_clear();
    #1;
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_hit", resp_hit, 0);
    chk("rst_resp_instr", resp_instruction, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_ready", req_ready, 1);
    chk("rst_no_resp", resp_valid, 0);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run(tbl[i].addr, tbl[i].w, tbl[i].fa, h);
      chk($sformatf("tbl%0d_hit", i), h, tbl[i].eh);
    end

    // Back-to-back hits, then hold of resp_instruction
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = 32'h0040_0000 + 32'(i * 4);
      req_addr = a;
      @(negedge clock);
      chk("b2b_valid", resp_valid, 1);
      chk("b2b_hit", resp_hit, 1);
      chk("b2b_data", resp_instruction, memfun(a));
    end
    req_valid = 1'b0;
    @(negedge clock);
    chk("idle_no_resp", resp_valid, 0);
    chk("instr_hold", resp_instruction, memfun(32'h0040_0008));

    // Flush then same address misses
    pulse_flush();
    run(32'h0040_0000, 1, 1'b0, h);
    chk("flush_miss", h, 0);
    // Flush on the fill's ack edge: that line survives
    run(32'h0040_0004, 2, 1'b1, h);
    run(32'h0040_0004, 0, 1'b0, h);
    chk("flush_ack_hit", h, 1);
    run(32'h0040_0000, 0, 1'b0, h);
    chk("flush_ack_others_cleared", h, 0);

    // Flush on the same edge as an accepted hit: hit served, line cleared
    req_valid = 1'b1; req_addr = 32'h0040_0004; flush = 1'b1;
    @(negedge clock);
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_req_valid", resp_valid, 1);
    chk("flush_req_hit", resp_hit, 1);
    chk("flush_req_data", resp_instruction, memfun(32'h0040_0004));
    model_clear();
    run(32'h0040_0004, 0, 1'b0, h);
    chk("flush_req_then_miss", h, 0);

    // Reset mid-fill
    req_valid = 1'b1; req_addr = 32'h0040_0010;
    @(negedge clock);
    req_valid = 1'b0;
    chk("rmf_mem_req", mem_req, 1);
    reset_n = 1'b0;
    #1;
    chk("rmf_mem_req_drop", mem_req, 0);
    chk("rmf_no_resp", resp_valid, 0);
    chk("rmf_mem_addr", mem_addr, 0);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      chk("rmf_stray_ack_resp", resp_valid, 0);
      chk("rmf_stray_ack_req", mem_req, 0);
      chk("rmf_ready", req_ready, 1);
    end
    mem_ack = 1'b0;
    model_clear();
    run(32'h0040_0010, 1, 1'b0, h);
    chk("rmf_rereq_miss", h, 0);

    // Zero-wait memory with ack tied high, unaligned address
    mem_ack = 1'b1; mem_rdata = memfun(32'h0040_0000);
    req_valid = 1'b1; req_addr = 32'h0040_0003;
    @(negedge clock);
    req_valid = 1'b0;
    chk("zw_no_resp_n1", resp_valid, 0);
    chk("zw_mem_req", mem_req, 1);
    chk("zw_mem_addr", mem_addr, 32'h0040_0000);
    @(negedge clock);
    chk("zw_resp_valid", resp_valid, 1);
    chk("zw_resp_hit", resp_hit, 0);
    chk("zw_resp_data", resp_instruction, 32'h2008_000A);
    @(negedge clock);
    chk("zw_ack_idle_ignored", resp_valid, 0);
    chk("zw_ack_idle_mem_req", mem_req, 0);
    mem_ack = 1'b0;
    model_install(32'h0040_0000);

    // Randomized fetches against the model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) pulse_flush();
      a = 32'h0040_0000 + (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(0, 3));
      run(a, int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0), h);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
